// File: rtl/delay_ctrl_pkg.sv
// Shared types and constants for the pushbutton-to-PIO conditioning block.
package delay_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } dc_state_t;

   localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic d,
   output logic q
);

   logic meta_p0;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         meta_p0 <= RST_VAL;
         q       <= RST_VAL;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/delay_ctrl_debounce.sv
// Synchronises and debounces a raw pushbutton into a clean delay-control level,
// plus a one-cycle press strobe and a wrapping press counter.
module delay_ctrl_debounce
   import delay_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter bit TOGGLE_MODE       = 1'b1,
   parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic                   button_in,
   output logic                   delay_ctrl_export,
   output logic                   press_pulse,
   output logic [PRESS_CNT_W-1:0] press_count
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_sync_p1;
   logic             act;
   dc_state_t        state;
   logic [CNT_W-1:0] cnt;

   // Flops reset to the released level so reset never looks like a press.
   sync_2ff #(
      .RST_VAL (BUTTON_ACTIVE_LOW)
   ) u_sync (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .d           (button_in),
      .q           (btn_sync_p1)
   );

   assign act = btn_sync_p1 ^ BUTTON_ACTIVE_LOW;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state             <= IDLE;
         cnt               <= '0;
         delay_ctrl_export <= 1'b0;
         press_pulse       <= 1'b0;
         press_count       <= '0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (act) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!act) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= HELD;
                  press_pulse <= 1'b1;
                  press_count <= press_count + PRESS_CNT_W'(1);
                  if (TOGGLE_MODE) delay_ctrl_export <= ~delay_ctrl_export;
                  else             delay_ctrl_export <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!act) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               // A bounce here falls back to HELD without re-arming a press.
               if (act) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  if (!TOGGLE_MODE) delay_ctrl_export <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_ctrl_debounce.sv
// Bench for delay_ctrl_debounce: toggle and follow instances side by side,
// table vectors, hand corner-case sequences and randomized traffic vs a model.
module tb_delay_ctrl_debounce;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b1;
   logic       t_exp, t_pulse, f_exp, f_pulse;
   logic [7:0] t_cnt, f_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses_seen = 0;

   always #5 clk = ~clk;

   delay_ctrl_debounce #(.DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b1), .BUTTON_ACTIVE_LOW(1'b1)) dut_t (
      .clk_clk           (clk),
      .reset_reset       (rst),
      .button_in         (btn),
      .delay_ctrl_export (t_exp),
      .press_pulse       (t_pulse),
      .press_count       (t_cnt)
   );

   delay_ctrl_debounce #(.DEBOUNCE_CYCLES(D), .TOGGLE_MODE(1'b0), .BUTTON_ACTIVE_LOW(1'b1)) dut_f (
      .clk_clk           (clk),
      .reset_reset       (rst),
      .button_in         (btn),
      .delay_ctrl_export (f_exp),
      .press_pulse       (f_pulse),
      .press_count       (f_cnt)
   );

   // Reference model: a press/release is accepted once the synchronised
   // level has disagreed with the debounced level for D+1 consecutive samples.
   logic       m_s1 = 1'b1, m_s2 = 1'b1, m_act;
   logic       m_level = 1'b0, m_tog = 1'b0, m_pulse = 1'b0;
   logic [7:0] m_cnt = 8'd0;
   int         m_run = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = 1'b1; m_s2 = 1'b1;
         m_level = 1'b0; m_tog = 1'b0; m_pulse = 1'b0;
         m_cnt = 8'd0; m_run = 0;
      end else begin
         m_act   = ~m_s2;
         m_pulse = 1'b0;
         if (m_act != m_level) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
               m_level = m_act;
               m_run   = 0;
               if (m_act) begin
                  m_pulse = 1'b1;
                  m_cnt   = m_cnt + 8'd1;
                  m_tog   = ~m_tog;
               end
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (t_pulse === 1'b1) pulses_seen++;
      check("model", {12'd0, t_exp, t_pulse, t_cnt, f_exp, f_pulse, f_cnt},
                     {12'd0, m_tog, m_pulse, m_cnt, m_level, m_pulse, m_cnt});
   endtask

   task automatic hold(input logic v, input int n);
      btn = v;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      pulses_seen = 0;
   endtask

   typedef struct {
      int         low;
      int         high;
      int         exp_pulses;
      logic       exp_tog;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      vecs[0] = '{low: 20, high: 30, exp_pulses: 1, exp_tog: 1'b1, exp_cnt: 8'd1};
      vecs[1] = '{low: 3,  high: 30, exp_pulses: 0, exp_tog: 1'b0, exp_cnt: 8'd0};
      vecs[2] = '{low: 7,  high: 30, exp_pulses: 0, exp_tog: 1'b0, exp_cnt: 8'd0};
      vecs[3] = '{low: 8,  high: 30, exp_pulses: 0, exp_tog: 1'b0, exp_cnt: 8'd0};
      vecs[4] = '{low: 9,  high: 30, exp_pulses: 1, exp_tog: 1'b1, exp_cnt: 8'd1};
      vecs[5] = '{low: 1,  high: 5,  exp_pulses: 0, exp_tog: 1'b0, exp_cnt: 8'd0};

      do_reset();
      check("reset_tog",   t_exp,   0);
      check("reset_pulse", t_pulse, 0);
      check("reset_cnt",   t_cnt,   0);
      check("reset_follow", f_exp,  0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         hold(1'b0, vecs[i].low);
         hold(1'b1, vecs[i].high);
         check($sformatf("vec%0d_pulses", i), pulses_seen, vecs[i].exp_pulses);
         check($sformatf("vec%0d_tog", i),    t_exp,       vecs[i].exp_tog);
         check($sformatf("vec%0d_cnt", i),    t_cnt,       vecs[i].exp_cnt);
         check($sformatf("vec%0d_follow", i), f_exp,       0);
      end

      // Clean press: pulse lands D+3 edges after the raw edge, one cycle wide.
      do_reset();
      btn = 1'b0;
      lat = 0;
      while (t_pulse !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("press_latency", lat, D + 3);
      tick();
      check("pulse_width", t_pulse, 0);
      hold(1'b0, 8);
      check("clean_tog", t_exp, 1);
      check("clean_follow", f_exp, 1);
      check("clean_cnt", t_cnt, 1);
      hold(1'b1, 20);

      // Bounce rejection.
      do_reset();
      hold(1'b0, 3); hold(1'b1, 2); hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 7);
      hold(1'b1, 20);
      check("bounce_pulses", pulses_seen, 0);
      check("bounce_tog", t_exp, 0);
      check("bounce_cnt", t_cnt, 0);

      // Release bounce.
      do_reset();
      hold(1'b0, 20); hold(1'b1, 4); hold(1'b0, 20);
      check("relbounce_follow_held", f_exp, 1);
      hold(1'b1, 30);
      check("relbounce_pulses", pulses_seen, 1);
      check("relbounce_cnt", t_cnt, 1);
      check("relbounce_tog", t_exp, 1);

      // Toggle sequence, follow instance alongside.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         hold(1'b0, 20);
         check($sformatf("toggle%0d_tog", i), t_exp, (i % 2 == 0) ? 1 : 0);
         check($sformatf("toggle%0d_follow_on", i), f_exp, 1);
         hold(1'b1, 20);
         check($sformatf("toggle%0d_follow_off", i), f_exp, 0);
      end
      check("toggle_cnt", t_cnt, 3);

      // Wrap 255 -> 0.
      do_reset();
      for (int i = 0; i < 255; i++) begin
         hold(1'b0, 12);
         hold(1'b1, 12);
      end
      check("wrap_pre_cnt", t_cnt, 255);
      pulses_seen = 0;
      hold(1'b0, 12);
      check("wrap_cnt", t_cnt, 0);
      check("wrap_pulse", pulses_seen, 1);
      hold(1'b1, 12);

      // Reset while PRESS_WAIT with cnt=5, button kept held.
      do_reset();
      btn = 1'b0;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_tog", t_exp, 0);
      check("midrst_pulse", t_pulse, 0);
      check("midrst_cnt", t_cnt, 0);
      check("midrst_follow", f_exp, 0);
      check("midrst_no_early_pulse", pulses_seen, 0);
      lat = 0;
      while (t_pulse !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("midrst_latency", lat, D + 3);
      check("midrst_cnt_after", t_cnt, 1);
      hold(1'b1, 20);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
      end
      hold(1'b1, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
